alu_arbiter: RTL and testbench

Shares one IEEE-754 ALU (op_a/op_b/op_code/mode_fp/round_mode/start -> result/valid_out/flags) among NUM_REQ requesters with round-robin fairness. Accepts one operation per grant and drives the ALU's start/valid_out handshake: hold start until valid_out, drop start, wait for valid_out low. Returns the result and flags to the granted requester. Includes a watchdog so that a hung ALU operation cannot stall the other requesters.

---
 rtl/alu_arb_pkg.sv | 30 +++
 rtl/alu_arbiter_rr_pick.sv | 33 +++
 rtl/alu_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM encoding, op codes,
// flag bit positions and the quiet-NaN patterns returned on a watchdog abort.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CLEAR = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    localparam int FLAG_INVALID   = 4;
    localparam int FLAG_DIV_ZERO  = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;
    localparam logic [31:0] QNAN_HP = 32'h0000_7E00;

    function automatic logic [31:0] qnan_for(input logic mode_fp);
        return mode_fp ? QNAN_SP : QNAN_HP;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after the
// pointer, wrapping around, so the pointer holder has lowest priority.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        cand    = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = IDX_W'((int'(ptr_i) + off) % NUM_REQ);
            if (req_i[cand]) begin
                grant_o       = '0;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one FP ALU between NUM_REQ requesters, with a
// watchdog abort. Define ALU_ARB_STATS_EN to add saturating activity counters.
//   state    | meaning
//   IDLE     | waiting for a request while the ALU valid_out is low
//   ISSUE    | alu_start held, watchdog running
//   CLEAR    | start dropped, waiting for ALU valid_out to fall
//   RESP     | response presented to the granted requester
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef ALU_ARB_STATS_EN
    output logic [31:0]           stat_ops,
    output logic [15:0]           stat_timeouts,
    output logic [31:0]           stat_busy,
`endif
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_op_a,
    input  logic [NUM_REQ*32-1:0] req_op_b,
    input  logic [NUM_REQ*3-1:0]  req_op_code,
    input  logic [NUM_REQ-1:0]    req_mode_fp,
    input  logic [NUM_REQ-1:0]    req_round_mode,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [31:0]           rsp_result,
    output logic [4:0]            rsp_flags,
    output logic                  rsp_timeout,
    output logic [31:0]           alu_op_a,
    output logic [31:0]           alu_op_b,
    output logic [2:0]            alu_op_code,
    output logic                  alu_mode_fp,
    output logic                  alu_round_mode,
    output logic                  alu_start,
    input  logic [31:0]           alu_result,
    input  logic                  alu_valid_out,
    input  logic [4:0]            alu_flags
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d, cur_idx_q, cur_idx_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic [31:0]      op_a_q, op_a_d, op_b_q, op_b_d;
    logic [2:0]       op_code_q, op_code_d;
    logic             mode_fp_q, mode_fp_d, round_q, round_d;
    logic [31:0]      rsp_result_q, rsp_result_d;
    logic [4:0]       rsp_flags_q, rsp_flags_d;
    logic             rsp_timeout_q, rsp_timeout_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [31:0]        sel_a, sel_b;
    logic [2:0]         sel_code;
    logic               sel_fp, sel_round;
    logic               rsp_hs;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        sel_code  = '0;
        sel_fp    = 1'b0;
        sel_round = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_a     = req_op_a[i*32 +: 32];
                sel_b     = req_op_b[i*32 +: 32];
                sel_code  = req_op_code[i*3 +: 3];
                sel_fp    = req_mode_fp[i];
                sel_round = req_round_mode[i];
            end
        end
    end

    assign rsp_hs = (state_q == ST_RESP) && rsp_ready[cur_idx_q];

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cur_idx_d     = cur_idx_q;
        wdog_d        = wdog_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        op_code_d     = op_code_q;
        mode_fp_d     = mode_fp_q;
        round_d       = round_q;
        rsp_result_d  = rsp_result_q;
        rsp_flags_d   = rsp_flags_q;
        rsp_timeout_d = rsp_timeout_q;
        req_ready     = '0;
        rsp_valid     = '0;
        unique case (state_q)
            ST_IDLE: begin
                // A high valid_out here is stale; granting now could capture it.
                if (pick_any && !alu_valid_out) begin
                    req_ready = pick_grant;
                    op_a_d    = sel_a;
                    op_b_d    = sel_b;
                    op_code_d = sel_code;
                    mode_fp_d = sel_fp;
                    round_d   = sel_round;
                    cur_idx_d = pick_idx;
                    wdog_d    = '0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (alu_valid_out) begin
                    rsp_result_d  = alu_result;
                    rsp_flags_d   = alu_flags;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_CLEAR;
                end else if (wdog_q == WD_LAST) begin
                    rsp_result_d               = qnan_for(mode_fp_q);
                    rsp_flags_d                = '0;
                    rsp_flags_d[FLAG_INVALID]  = 1'b1;
                    rsp_timeout_d              = 1'b1;
                    state_d                    = ST_CLEAR;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_CLEAR: begin
                if (!alu_valid_out) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid[cur_idx_q] = 1'b1;
                if (rsp_hs) begin
                    ptr_d   = cur_idx_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= IDX_W'(NUM_REQ - 1);
            cur_idx_q     <= '0;
            wdog_q        <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            op_code_q     <= '0;
            mode_fp_q     <= 1'b0;
            round_q       <= 1'b0;
            rsp_result_q  <= '0;
            rsp_flags_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cur_idx_q     <= cur_idx_d;
            wdog_q        <= wdog_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            op_code_q     <= op_code_d;
            mode_fp_q     <= mode_fp_d;
            round_q       <= round_d;
            rsp_result_q  <= rsp_result_d;
            rsp_flags_q   <= rsp_flags_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign alu_start      = (state_q == ST_ISSUE);
    assign alu_op_a       = op_a_q;
    assign alu_op_b       = op_b_q;
    assign alu_op_code    = op_code_q;
    assign alu_mode_fp    = mode_fp_q;
    assign alu_round_mode = round_q;
    assign rsp_result     = rsp_result_q;
    assign rsp_flags      = rsp_flags_q;
    assign rsp_timeout    = rsp_timeout_q;

`ifdef ALU_ARB_STATS_EN
    logic [31:0] stat_ops_q, stat_busy_q;
    logic [15:0] stat_to_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_ops_q  <= '0;
            stat_to_q   <= '0;
            stat_busy_q <= '0;
        end else begin
            if (rsp_hs && !(&stat_ops_q))                  stat_ops_q  <= stat_ops_q + 32'd1;
            if (rsp_hs && rsp_timeout_q && !(&stat_to_q))  stat_to_q   <= stat_to_q + 16'd1;
            if ((state_q != ST_IDLE) && !(&stat_busy_q))   stat_busy_q <= stat_busy_q + 32'd1;
        end
    end

    assign stat_ops      = stat_ops_q;
    assign stat_timeouts = stat_to_q;
    assign stat_busy     = stat_busy_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU responder, predicted
// responses queued at stimulus time and compared as responses appear.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0, req_ready, req_mode_fp = '0, req_round_mode = '0;
    logic [N-1:0]    rsp_valid, rsp_ready = '0;
    logic [N*32-1:0] req_op_a = '0, req_op_b = '0;
    logic [N*3-1:0]  req_op_code = '0;
    logic [31:0]     rsp_result;
    logic [4:0]      rsp_flags;
    logic            rsp_timeout;
    logic [31:0]     alu_op_a, alu_op_b;
    logic [2:0]      alu_op_code;
    logic            alu_mode_fp, alu_round_mode, alu_start;
    logic [31:0]     alu_result = '0;
    logic            alu_valid_out = 1'b0;
    logic [4:0]      alu_flags = '0;
`ifdef ALU_ARB_STATS_EN
    logic [31:0]     stat_ops, stat_busy;
    logic [15:0]     stat_timeouts;
`endif

    alu_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(64)) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef ALU_ARB_STATS_EN
        .stat_ops       (stat_ops),
        .stat_timeouts  (stat_timeouts),
        .stat_busy      (stat_busy),
`endif
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op_a       (req_op_a),
        .req_op_b       (req_op_b),
        .req_op_code    (req_op_code),
        .req_mode_fp    (req_mode_fp),
        .req_round_mode (req_round_mode),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_result     (rsp_result),
        .rsp_flags      (rsp_flags),
        .rsp_timeout    (rsp_timeout),
        .alu_op_a       (alu_op_a),
        .alu_op_b       (alu_op_b),
        .alu_op_code    (alu_op_code),
        .alu_mode_fp    (alu_mode_fp),
        .alu_round_mode (alu_round_mode),
        .alu_start      (alu_start),
        .alu_result     (alu_result),
        .alu_valid_out  (alu_valid_out),
        .alu_flags      (alu_flags)
    );

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic [4:0]  flg;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0, n_err = 0;

    // Behavioural ALU: two directed IEEE cases, otherwise an arbitrary mixing function.
    function automatic logic [36:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op, input logic fp);
        if (!fp && op == OP_ADD && a[15:0] == 16'h4000 && b[15:0] == 16'h3C00)
            return {5'b00000, 32'h0000_4200};
        if (fp && op == OP_DIV && b == 32'd0)
            return {5'b01000, 32'h7F80_0000};
        return {a[4:0] ^ b[4:0], a + (b ^ {29'd0, op})};
    endfunction

    function automatic exp_t mk(input int idx, input logic [36:0] fr, input logic to);
        exp_t e;
        e.idx = idx;
        e.res = fr[31:0];
        e.flg = fr[36:32];
        e.to  = to;
        return e;
    endfunction

    int alu_lat = 0;
    bit alu_hang = 1'b0, alu_force = 1'b0;
    int alu_cnt = 0;

    always @(posedge clk) begin
        #2;
        if (alu_start && !alu_hang && alu_cnt >= alu_lat) begin
            {alu_flags, alu_result} = alu_ref(alu_op_a, alu_op_b, alu_op_code, alu_mode_fp);
            alu_valid_out = 1'b1;
        end else begin
            alu_valid_out = alu_force;
        end
        if (alu_start) alu_cnt++;
        else           alu_cnt = 0;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    int   acc_cnt [N];
    int   left [N];
    bit   in_rsp = 1'b0, busy_flag = 1'b0;
    int   hold_cfg = 0, hold_left = 0, n_done = 0, start_cnt = 0, busy_cnt = 0;
    exp_t cur;

    // One clock: sample at negedge, act on the response port, update requesters after the edge.
    task automatic tick();
        logic [N-1:0] rr, ev;
        bit acc;
        @(negedge clk);
        rr  = rst ? req_ready : '0;
        acc = 1'b0;
        if (alu_start) start_cnt++;
        if (busy_flag) busy_cnt++;
        if (rsp_valid != '0) begin
            chk("no_grant_during_rsp", req_ready, '0);
            if (!in_rsp) begin
                in_rsp    = 1'b1;
                hold_left = hold_cfg;
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", rsp_valid, '0);
                    cur = mk(0, '0, 1'b0);
                end else begin
                    cur = sb.pop_front();
                end
                ev = N'(1) << cur.idx;
                chk("rsp_idx", rsp_valid, ev);
                chk("rsp_result", rsp_result, cur.res);
                chk("rsp_flags", rsp_flags, cur.flg);
                chk("rsp_timeout", rsp_timeout, cur.to);
                chk("start_low_in_rsp", alu_start, 1'b0);
            end else begin
                ev = N'(1) << cur.idx;
                chk("hold_valid", rsp_valid, ev);
                chk("hold_result", rsp_result, cur.res);
                chk("hold_flags", rsp_flags, cur.flg);
            end
            if (hold_left == 0) begin
                rsp_ready = rsp_valid;
                acc       = 1'b1;
            end else begin
                hold_left--;
                rsp_ready = ~rsp_valid;
            end
        end else begin
            rsp_ready = '0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rr[i]) begin
                acc_cnt[i]++;
                busy_flag = 1'b1;
                if (left[i] > 0) left[i]--;
                if (left[i] == 0) req_valid[i] = 1'b0;
            end
        end
        if (acc) begin
            rsp_ready = '0;
            in_rsp    = 1'b0;
            busy_flag = 1'b0;
            n_done++;
        end
    endtask

    task automatic run_until(input int target, input int budget);
        int k = 0;
        while (n_done < target && k < budget) begin
            tick();
            k++;
        end
        chk("rsp_count", n_done, target);
    endtask

    task automatic start_req(input int i, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] op, input logic fp, input int cnt);
        req_op_a[i*32 +: 32]  = a;
        req_op_b[i*32 +: 32]  = b;
        req_op_code[i*3 +: 3] = op;
        req_mode_fp[i]        = fp;
        left[i]               = cnt;
        req_valid[i]          = 1'b1;
    endtask

    task automatic clear_state();
        sb.delete();
        in_rsp    = 1'b0;
        busy_flag = 1'b0;
        busy_cnt  = 0;
        rsp_ready = '0;
        n_done    = 0;
        for (int i = 0; i < N; i++) begin
            acc_cnt[i] = 0;
            left[i]    = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        clear_state();
    endtask

    initial begin
        #400000;
        $display("FAIL global_time_limit: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        int k;
        clear_state();
        tick();
        tick();
        chk("rst_req_ready", req_ready, '0);
        chk("rst_rsp_valid", rsp_valid, '0);
        chk("rst_alu_start", alu_start, 1'b0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_flags", rsp_flags, 5'd0);
        chk("rst_rsp_timeout", rsp_timeout, 1'b0);
        chk("rst_alu_op_a", alu_op_a, 32'd0);
        rst = 1'b1;

        // Single HP add from requester 0
        alu_lat = 0;
        sb.push_back(mk(0, {5'b00000, 32'h0000_4200}, 1'b0));
        start_req(0, 32'h0000_4000, 32'h0000_3C00, OP_ADD, 1'b0, 1);
        run_until(1, 50);
        chk("t1_ready_pulses", acc_cnt[0], 1);
        chk("t1_op_a_held", alu_op_a, 32'h0000_4000);

        // Requesters 0 and 2 contend continuously: strict alternation from reset
        do_reset();
        alu_lat = 3;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) sb.push_back(mk(0, alu_ref(32'h3F80_0001, 32'h4000_0012, OP_MUL, 1'b1), 1'b0));
            else            sb.push_back(mk(2, alu_ref(32'h0000_3555, 32'h0000_4AAA, OP_SUB, 1'b0), 1'b0));
        end
        start_req(0, 32'h3F80_0001, 32'h4000_0012, OP_MUL, 1'b1, 4);
        start_req(2, 32'h0000_3555, 32'h0000_4AAA, OP_SUB, 1'b0, 4);
        run_until(8, 400);
        chk("t2_grants_req0", acc_cnt[0], 4);
        chk("t2_grants_req2", acc_cnt[2], 4);

        // Held responses: pointer at 2 so requester 3 goes before requester 1
        n_done   = 0;
        alu_lat  = 1;
        hold_cfg = 10;
        req_round_mode[1] = 1'b1;
        sb.push_back(mk(3, alu_ref(32'h4049_0FDB, 32'h3F80_0000, OP_ADD, 1'b1), 1'b0));
        sb.push_back(mk(1, {5'b01000, 32'h7F80_0000}, 1'b0));
        start_req(1, 32'h3F80_0000, 32'h0000_0000, OP_DIV, 1'b1, 1);
        start_req(3, 32'h4049_0FDB, 32'h3F80_0000, OP_ADD, 1'b1, 1);
        run_until(2, 200);
        hold_cfg = 0;
        chk("t3_round_passthru", alu_round_mode, 1'b1);
        chk("t3_op_code_held", alu_op_code, OP_DIV);
        chk("t3_mode_fp_held", alu_mode_fp, 1'b1);

        // Hung ALU: watchdog abort after 64 ISSUE cycles, then stale valid blocks grants
        n_done    = 0;
        alu_hang  = 1'b1;
        start_cnt = 0;
        sb.push_back(mk(1, {5'b10000, 32'h7FC0_0000}, 1'b1));
        start_req(1, 32'h4000_0000, 32'h4040_0000, OP_MUL, 1'b1, 1);
        run_until(1, 200);
        chk("t4_issue_cycles", start_cnt, 64);
        alu_hang   = 1'b0;
        alu_force  = 1'b1;
        acc_cnt[0] = 0;
        sb.push_back(mk(0, alu_ref(32'h11, 32'h22, OP_SUB, 1'b1), 1'b0));
        start_req(0, 32'h0000_0011, 32'h0000_0022, OP_SUB, 1'b1, 1);
        repeat (8) tick();
        chk("t4_no_grant_stale_valid", acc_cnt[0], 0);
        alu_force = 1'b0;
        run_until(2, 100);

        // Reset in the middle of ISSUE discards the op and resets the pointer
        n_done = 0;
        sb.push_back(mk(1, alu_ref(32'h5, 32'h9, OP_ADD, 1'b1), 1'b0));
        start_req(1, 32'h0000_0005, 32'h0000_0009, OP_ADD, 1'b1, 1);
        run_until(1, 100);
        alu_hang = 1'b1;
        start_req(2, 32'h0000_0777, 32'h0000_0123, OP_MUL, 1'b1, 1);
        k = 0;
        while (!alu_start && k < 20) begin
            tick();
            k++;
        end
        chk("t5_reached_issue", alu_start, 1'b1);
        rst = 1'b0;
        tick();
        chk("t5_start_dropped", alu_start, 1'b0);
        chk("t5_rsp_valid_clear", rsp_valid, '0);
        chk("t5_rsp_result_clear", rsp_result, 32'd0);
        rst = 1'b1;
        clear_state();
        alu_hang = 1'b0;
        sb.push_back(mk(0, alu_ref(32'h0000_0A0A, 32'h0000_0B0B, OP_SUB, 1'b0), 1'b0));
        sb.push_back(mk(2, alu_ref(32'h0000_0C0C, 32'h0000_0D0D, OP_ADD, 1'b0), 1'b0));
        start_req(0, 32'h0000_0A0A, 32'h0000_0B0B, OP_SUB, 1'b0, 1);
        start_req(2, 32'h0000_0C0C, 32'h0000_0D0D, OP_ADD, 1'b0, 1);
        run_until(2, 200);

`ifdef ALU_ARB_STATS_EN
        do_reset();
        chk("st_ops_reset", stat_ops, 32'd0);
        chk("st_busy_reset", stat_busy, 32'd0);
        sb.push_back(mk(0, alu_ref(32'h1, 32'h2, OP_ADD, 1'b1), 1'b0));
        start_req(0, 32'h0000_0001, 32'h0000_0002, OP_ADD, 1'b1, 1);
        run_until(1, 100);
        alu_hang = 1'b1;
        sb.push_back(mk(1, {5'b10000, 32'h0000_7E00}, 1'b1));
        start_req(1, 32'h0000_3C00, 32'h0000_3C00, OP_MUL, 1'b0, 1);
        run_until(2, 200);
        alu_hang = 1'b0;
        sb.push_back(mk(2, alu_ref(32'h3, 32'h4, OP_SUB, 1'b1), 1'b0));
        start_req(2, 32'h0000_0003, 32'h0000_0004, OP_SUB, 1'b1, 1);
        run_until(3, 100);
        tick();
        chk("st_ops", stat_ops, 32'd3);
        chk("st_timeouts", stat_timeouts, 16'd1);
        chk("st_busy", stat_busy, busy_cnt);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
